// File: rtl/brew_pkg.sv
// Shared types and constants for the beverage brewing controller.
package brew_pkg;

  localparam int unsigned DRINK_W    = 2;
  localparam int unsigned NUM_DRINKS = 4;
  localparam int unsigned TCNT_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HEAT  = 2'd1,
    S_BREW  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  // Brew durations in ticks, indexed by drink; entry 0 is the least significant byte.
  typedef logic [NUM_DRINKS-1:0][TCNT_W-1:0] brew_tbl_t;

  localparam brew_tbl_t BREW_T_TBL = {8'd15, 8'd30, 8'd20, 8'd10};

  // Menu step; the 2-bit index wraps 3 -> 0 on its own.
  function automatic logic [DRINK_W-1:0] next_drink(input logic [DRINK_W-1:0] d);
    return d + DRINK_W'(1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, phase restarted by clr.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Tick is registered one count early so it lines up with the last count of each period.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      r_tick <= (r_cnt == CNT_PRE);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/brew_ctrl.sv
// Coffee-machine brew sequencer: drink selection, heater pre-heat, timed pump brew,
// cancel and dry-tank error handling.
module brew_ctrl
  import brew_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned HEAT_T   = 30,
  parameter brew_tbl_t   BREW_T   = BREW_T_TBL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_down,
  input  logic               start_down,
  input  logic               cancel_down,
  input  logic               water_ok,
  output logic [DRINK_W-1:0] drink,
  output logic               heater,
  output logic               pump,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t              r_state;
  logic [DRINK_W-1:0]  r_drink;
  logic [DRINK_W-1:0]  r_brew_sel;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_heater;
  logic                r_pump;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_tick;
  logic                w_clr;
  logic                w_in_run;
  logic [TCNT_W-1:0]   w_heat_last;
  logic [TCNT_W-1:0]   w_brew_last;
  logic [TCNT_W-1:0]   w_target;
  logic                w_phase_end;
  logic                w_to_heat;
  logic                w_to_err_start;
  logic                w_water_fault;
  logic                w_cancel_run;
  logic                w_err_exit;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_heat_last = TCNT_W'(HEAT_T - 1);
  assign w_brew_last = BREW_T[r_brew_sel] - TCNT_W'(1);

  // Transition conditions; any state change restarts the prescaler and tick counter.
  always_comb begin
    w_in_run       = (r_state == S_HEAT) || (r_state == S_BREW);
    w_target       = (r_state == S_HEAT) ? w_heat_last : w_brew_last;
    w_phase_end    = w_in_run && w_tick && (r_tcnt == w_target);
    w_to_heat      = (r_state == S_IDLE) && start_down && water_ok;
    w_to_err_start = (r_state == S_IDLE) && start_down && !water_ok;
    w_water_fault  = w_in_run && !water_ok;
    w_cancel_run   = w_in_run && water_ok && cancel_down;
    w_err_exit     = (r_state == S_ERROR) && cancel_down && water_ok;
    w_clr          = w_to_heat || w_to_err_start || w_water_fault ||
                     w_cancel_run || w_phase_end || w_err_exit;
  end

  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_tcnt <= r_tcnt + TCNT_W'(1);
    end
  end

  // Sequencer; water fault beats cancel, and cancel beats phase completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_drink    <= '0;
      r_brew_sel <= '0;
      r_heater   <= 1'b0;
      r_pump     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_to_heat) begin
            r_state    <= S_HEAT;
            r_brew_sel <= r_drink;
            r_heater   <= 1'b1;
            r_busy     <= 1'b1;
          end else if (w_to_err_start) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
          end else if (sel_down) begin
            r_drink <= next_drink(r_drink);
          end
        end
        S_HEAT, S_BREW: begin
          if (w_water_fault) begin
            r_state  <= S_ERROR;
            r_heater <= 1'b0;
            r_pump   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b1;
          end else if (w_cancel_run) begin
            r_state  <= S_IDLE;
            r_heater <= 1'b0;
            r_pump   <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_phase_end) begin
            if (r_state == S_HEAT) begin
              r_state <= S_BREW;
              r_pump  <= 1'b1;
            end else begin
              r_state  <= S_IDLE;
              r_heater <= 1'b0;
              r_pump   <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end
        S_ERROR: begin
          if (w_err_exit) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign drink  = r_drink;
  assign heater = r_heater;
  assign pump   = r_pump;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_brew_ctrl.sv
// Scoreboard bench for brew_ctrl with a short tick and small brew table.
module tb_brew_ctrl;
  import brew_pkg::*;

  localparam int TD = 4;
  localparam int HT = 2;
  localparam int BT [4] = '{1, 2, 3, 4};
  localparam int HB = HT * TD;

  typedef struct packed {
    logic [1:0] drink;
    logic       heater;
    logic       pump;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, sel_down, start_down, cancel_down, water_ok;
  logic [1:0] drink;
  logic       heater, pump, busy, done, err;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [1:0] cur_drink;

  brew_ctrl #(
    .TICK_DIV (TD),
    .HEAT_T   (HT),
    .BREW_T   ({8'd4, 8'd3, 8'd2, 8'd1})
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_down    (sel_down),
    .start_down  (start_down),
    .cancel_down (cancel_down),
    .water_ok    (water_ok),
    .drink       (drink),
    .heater      (heater),
    .pump        (pump),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] d, input logic h, input logic p,
                              input logic b, input logic dn, input logic e);
    exp_t x;
    x.drink = d; x.heater = h; x.pump = p; x.busy = b; x.done = dn; x.err = e;
    return x;
  endfunction

  function automatic exp_t observed();
    return {drink, heater, pump, busy, done, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sel_down = 1'b0; start_down = 1'b0; cancel_down = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got, e;
    for (int k = 1; k <= 3; k++) sb.push_back(mk(2'd0, 0, 0, 0, 0, 0));
    water_ok = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      rst = (k < 3);
      start_down = (k < 3);
      sel_down = (k < 3);
      step();
      got = observed(); e = sb.pop_front(); n_chk++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset cyc %0d: got %b expected %b", k, got, e);
      end
    end
    clear_inputs();
    cur_drink = 2'd0;
  endtask

  task automatic test_brew();
    exp_t got, e;
    int bb, total;
    bb = BT[cur_drink] * TD;
    total = HB + bb + 3;
    for (int k = 1; k <= total; k++) begin
      if (k <= HB + bb)          sb.push_back(mk(cur_drink, 1, (k > HB), 1, 0, 0));
      else if (k == HB + bb + 1) sb.push_back(mk(cur_drink, 0, 0, 0, 1, 0));
      else                       sb.push_back(mk(cur_drink, 0, 0, 0, 0, 0));
    end
    for (int k = 1; k <= total; k++) begin
      start_down = (k == 1);
      step();
      got = observed(); e = sb.pop_front(); n_chk++;
      if (got !== e) begin
        n_err++;
        $display("FAIL brew d%0d cyc N+%0d: got %b expected %b", cur_drink, k, got, e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_select();
    exp_t got, e;
    logic [1:0] d;
    d = cur_drink;
    for (int i = 0; i < 5; i++) begin
      d = 2'((int'(d) + 1) % 4);
      sb.push_back(mk(d, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 5; i++) begin
      sel_down = 1'b1;
      step();
      sel_down = 1'b0;
      got = observed(); e = sb.pop_front(); n_chk++;
      if (got !== e) begin
        n_err++;
        $display("FAIL select pulse %0d: got %b expected %b", i, got, e);
      end
    end
    cur_drink = d;
  endtask

  task automatic test_cancel(input int at, input string nm);
    exp_t got, e;
    int bb, total;
    bb = BT[cur_drink] * TD;
    total = HB + bb + 4;
    for (int k = 1; k <= total; k++) begin
      if (k <= at) sb.push_back(mk(cur_drink, 1, (k > HB), 1, 0, 0));
      else         sb.push_back(mk(cur_drink, 0, 0, 0, 0, 0));
    end
    for (int k = 1; k <= total; k++) begin
      start_down = (k == 1);
      cancel_down = (k == at + 1);
      step();
      got = observed(); e = sb.pop_front(); n_chk++;
      if (got !== e) begin
        n_err++;
        $display("FAIL cancel_%s cyc N+%0d: got %b expected %b", nm, k, got, e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_water_brew();
    exp_t got, e;
    int j;
    for (int k = 1; k <= HB + 7; k++) begin
      j = k - HB - 1;
      if (j <= 0)      sb.push_back(mk(cur_drink, 1, (k > HB), 1, 0, 0));
      else if (j <= 4) sb.push_back(mk(cur_drink, 0, 0, 0, 0, 1));
      else             sb.push_back(mk(cur_drink, 0, 0, 0, 0, 0));
    end
    for (int k = 1; k <= HB + 7; k++) begin
      j = k - HB - 1;
      water_ok    = !(j >= 1 && j <= 3);
      start_down  = (k == 1) || (j == 3);
      sel_down    = (j == 3);
      cancel_down = (j == 2) || (j == 5);
      step();
      got = observed(); e = sb.pop_front(); n_chk++;
      if (got !== e) begin
        n_err++;
        $display("FAIL water_brew cyc N+%0d: got %b expected %b", k, got, e);
      end
    end
    clear_inputs();
    water_ok = 1'b1;
  endtask

  task automatic test_start_dry();
    exp_t got, e;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 3 || k == 7)   sb.push_back(mk(cur_drink, 0, 0, 0, 0, 1));
      else if (k == 5 || k == 6) sb.push_back(mk(cur_drink, 1, 0, 1, 0, 0));
      else                    sb.push_back(mk(cur_drink, 0, 0, 0, 0, 0));
    end
    for (int k = 1; k <= 8; k++) begin
      water_ok    = (k >= 4) && (k != 7);
      start_down  = (k == 1) || (k == 5);
      cancel_down = (k == 4) || (k == 7) || (k == 8);
      step();
      got = observed(); e = sb.pop_front(); n_chk++;
      if (got !== e) begin
        n_err++;
        $display("FAIL start_dry cyc %0d: got %b expected %b", k, got, e);
      end
    end
    clear_inputs();
    water_ok = 1'b1;
  endtask

  task automatic test_sel_in_heat();
    exp_t got, e;
    logic [1:0] nxt;
    nxt = 2'((int'(cur_drink) + 1) % 4);
    for (int k = 1; k <= 3; k++) sb.push_back(mk(cur_drink, 1, 0, 1, 0, 0));
    sb.push_back(mk(cur_drink, 0, 0, 0, 0, 0));
    sb.push_back(mk(nxt, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      start_down  = (k == 1);
      sel_down    = (k == 3) || (k == 5);
      cancel_down = (k == 4);
      step();
      got = observed(); e = sb.pop_front(); n_chk++;
      if (got !== e) begin
        n_err++;
        $display("FAIL sel_in_heat cyc %0d: got %b expected %b", k, got, e);
      end
    end
    clear_inputs();
    cur_drink = nxt;
  endtask

  task automatic test_reset_mid();
    exp_t got, e;
    for (int k = 1; k <= HB + 2; k++) sb.push_back(mk(cur_drink, 1, (k > HB), 1, 0, 0));
    sb.push_back(mk(2'd0, 0, 0, 0, 0, 0));
    sb.push_back(mk(2'd0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= HB + 4; k++) begin
      start_down = (k == 1);
      rst = (k == HB + 3);
      step();
      got = observed(); e = sb.pop_front(); n_chk++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_mid cyc N+%0d: got %b expected %b", k, got, e);
      end
    end
    clear_inputs();
    rst = 1'b0;
    cur_drink = 2'd0;
  endtask

  initial begin
    rst = 1'b1;
    water_ok = 1'b1;
    cur_drink = 2'd0;
    clear_inputs();
    test_reset();
    test_brew();
    test_select();
    test_brew();
    test_cancel(5, "mid_heat");
    test_cancel(HB, "heat_last");
    test_cancel(HB + BT[cur_drink] * TD, "brew_last");
    test_water_brew();
    test_start_dry();
    test_sel_in_heat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
